// File: rtl/kbd_event_writer.sv
// kbd_event_writer
//   Upstream feeder for the PIA1 keyboard-matrix cache. Key press/release
//   events from the RPi bridge are buffered in a FIFO. A shadow matrix of
//   ROWS rows is kept, active-low (0 = pressed). Each event becomes one bus
//   write of the updated row byte to $E800+row. The write uses the same
//   addr/data_out/pi_write_strobe bus that the cache latches from.
//   After reset, every row is first written with 8'hFF (INIT sweep).
//
// Parameters
//   FIFO_DEPTH  event FIFO entries (power of two, >= 2)
//   ROWS        keyboard rows; writes go to $E800..$E800+ROWS-1
//
// Ports
//   clk, res_b        clock; asynchronous active-low reset
//   evt_valid/ready   event handshake; evt_data = {pressed, row[3:0], col[2:0]}
//   bus_req/bus_gnt   shared-bus request/grant (grant sampled only in REQ)
//   addr, data_out    write address ($E800+row) and row byte
//   pi_write_strobe   one-cycle write strobe (destination latches on fall)
//   busy              FIFO non-empty or FSM not idle
//   err_count         events dropped for a bad row, saturating at 8'hFF
//
// Build option
//   KBD_CLEAR_EN : evt_data == 8'hFF means "release all". All shadow rows
//                  are cleared and the INIT sweep is rerun.
module kbd_event_writer #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ROWS       = 10
) (
  input  logic        clk,
  input  logic        res_b,
  input  logic        evt_valid,
  output logic        evt_ready,
  input  logic [7:0]  evt_data,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [16:0] addr,
  output logic [7:0]  data_out,
  output logic        pi_write_strobe,
  output logic        busy,
  output logic [7:0]  err_count
);

  localparam int unsigned PW   = $clog2(FIFO_DEPTH);
  localparam logic [16:0] BASE = 17'hE800;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_POP, S_REQ, S_SETUP, S_STROBE, S_HOLD
  } state_t;

  state_t      state;
  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  logic        full, push, retire;

  logic [7:0]  shadow [ROWS];
  logic        sweeping;
  logic [3:0]  init_row;

  logic [7:0]  head;
  logic [3:0]  head_row;
  logic [2:0]  head_col;
  logic        head_pressed, head_bad, is_clear;
  logic [7:0]  upd_row;

  assign full      = (count == (PW+1)'(FIFO_DEPTH));
  assign evt_ready = !full && !sweeping;
  assign push      = evt_valid && evt_ready;
  assign busy      = (count != '0) || (state != S_IDLE);

  assign head         = fifo_mem[rd_ptr];
  assign head_row     = head[6:3];
  assign head_col     = head[2:0];
  assign head_pressed = head[7];

`ifdef KBD_CLEAR_EN
  assign is_clear = (head == 8'hFF);
`else
  assign is_clear = 1'b0;
`endif

  assign head_bad = !is_clear && ({28'd0, head_row} >= ROWS);

  // A valid event stays at the FIFO head until its write completes in HOLD.
  // Its slot is therefore freed only at HOLD. Dropped events and clears are
  // retired directly at POP.
  assign retire = (state == S_POP  && (head_bad || is_clear)) ||
                  (state == S_HOLD && !sweeping);

  always_comb begin
    upd_row = 8'hFF;
    if (!head_bad && !is_clear) begin
      upd_row           = shadow[head_row];
      upd_row[head_col] = ~head_pressed;
    end
  end

  // FIFO storage carries no reset; pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= evt_data;
  end

  always_ff @(posedge clk or negedge res_b) begin
    if (!res_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (retire) rd_ptr <= rd_ptr + 1'b1;
      case ({push, retire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge res_b) begin
    if (!res_b) begin
      state           <= S_INIT;
      sweeping        <= 1'b1;
      init_row        <= '0;
      bus_req         <= 1'b0;
      pi_write_strobe <= 1'b0;
      addr            <= BASE;
      data_out        <= 8'hFF;
      err_count       <= '0;
      for (int unsigned i = 0; i < ROWS; i++) shadow[i] <= 8'hFF;
    end else begin
      case (state)
        S_INIT: begin
          addr     <= BASE + 17'(init_row);
          data_out <= 8'hFF;
          bus_req  <= 1'b1;
          state    <= S_REQ;
        end
        S_IDLE: begin
          if (count != '0) state <= S_POP;
        end
        S_POP: begin
          if (is_clear) begin
            for (int unsigned i = 0; i < ROWS; i++) shadow[i] <= 8'hFF;
            sweeping <= 1'b1;
            init_row <= '0;
            state    <= S_INIT;
          end else if (head_bad) begin
            if (err_count != 8'hFF) err_count <= err_count + 1'b1;
            state <= S_IDLE;
          end else begin
            shadow[head_row] <= upd_row;
            addr             <= BASE + 17'(head_row);
            data_out         <= upd_row;
            bus_req          <= 1'b1;
            state            <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus_gnt) state <= S_SETUP;
        end
        S_SETUP: begin
          pi_write_strobe <= 1'b1;
          state           <= S_STROBE;
        end
        S_STROBE: begin
          pi_write_strobe <= 1'b0;
          state           <= S_HOLD;
        end
        S_HOLD: begin
          bus_req <= 1'b0;
          if (sweeping) begin
            if ({28'd0, init_row} == ROWS - 1) begin
              sweeping <= 1'b0;
              state    <= S_IDLE;
            end else begin
              init_row <= init_row + 1'b1;
              state    <= S_INIT;
            end
          end else begin
            // The current head is retired on this edge. Any further queued
            // event goes straight to POP, so one event takes 5 clocks.
            state <= (count > (PW+1)'(1)) ? S_POP : S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kbd_event_writer.sv
module tb_kbd_event_writer;

  logic        clk;
  logic        res_b;
  logic        evt_valid;
  logic        evt_ready;
  logic [7:0]  evt_data;
  logic        bus_req;
  logic        bus_gnt;
  logic [16:0] addr;
  logic [7:0]  data_out;
  logic        pi_write_strobe;
  logic        busy;
  logic [7:0]  err_count;

  kbd_event_writer #(.FIFO_DEPTH(16), .ROWS(10)) dut (
    .clk             (clk),
    .res_b           (res_b),
    .evt_valid       (evt_valid),
    .evt_ready       (evt_ready),
    .evt_data        (evt_data),
    .bus_req         (bus_req),
    .bus_gnt         (bus_gnt),
    .addr            (addr),
    .data_out        (data_out),
    .pi_write_strobe (pi_write_strobe),
    .busy            (busy),
    .err_count       (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;
  int unsigned push_cyc, strobe_cyc;
  int unsigned strobe_long = 0;
  int unsigned unstable    = 0;
  logic        prev_strobe = 1'b0;
  logic [24:0] prev_ad     = '0;
  logic [24:0] wq [$];
  logic [24:0] eq [$];
  logic [7:0]  tb_sh [10];
  logic [7:0]  err_base;

  always @(posedge clk) cyc <= cyc + 1;

  // Bus observer: logs each write at the strobe rise. It also flags two
  // faults: a strobe longer than one cycle, and addr/data that changed
  // between SETUP and STROBE.
  always @(negedge clk) begin
    if (pi_write_strobe) begin
      if (prev_strobe) strobe_long++;
      else begin
        wq.push_back({addr, data_out});
        strobe_cyc = cyc;
        if ({addr, data_out} != prev_ad) unstable++;
      end
    end
    prev_strobe = pi_write_strobe;
    prev_ad     = {addr, data_out};
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic push_evt(input logic [7:0] d);
    int unsigned n;
    step;
    evt_valid = 1'b1;
    evt_data  = d;
    n = 0;
    while (!evt_ready && n < 300) begin
      step;
      n++;
    end
    if (!evt_ready) begin
      check("push_timeout", 32'(evt_ready), 32'd1);
      evt_valid = 1'b0;
    end else begin
      @(posedge clk);
      step;
      push_cyc  = cyc;
      evt_valid = 1'b0;
    end
  endtask

  task automatic wait_writes(input int unsigned n, input int unsigned budget);
    int unsigned k;
    k = 0;
    while (wq.size() < n && k < budget) begin
      step;
      k++;
    end
    check("write_count", 32'(wq.size()), 32'(n));
  endtask

  task automatic wait_idle(input int unsigned budget);
    int unsigned k;
    k = 0;
    while (busy && k < budget) begin
      step;
      k++;
    end
    check("idle", 32'(busy), 32'd0);
  endtask

  task automatic wait_ready(input int unsigned budget);
    int unsigned k;
    k = 0;
    while (!evt_ready && k < budget) begin
      step;
      k++;
    end
    check("sweep_done_ready", 32'(evt_ready), 32'd1);
  endtask

  task automatic expect_sweep;
    for (int unsigned i = 0; i < 10; i++) begin
      eq.push_back({17'hE800 + 17'(i), 8'hFF});
      tb_sh[i] = 8'hFF;
    end
  endtask

  task automatic expect_evt(input logic [7:0] d);
    logic [3:0] r;
    logic [7:0] v;
    r = d[6:3];
    v = tb_sh[r];
    v[d[2:0]] = ~d[7];
    tb_sh[r] = v;
    eq.push_back({17'hE800 + 17'(r), v});
  endtask

  task automatic compare_writes(input string tag);
    logic [24:0] g, e;
    while (eq.size() > 0) begin
      e = eq.pop_front();
      g = (wq.size() > 0) ? wq.pop_front() : 25'h0;
      check(tag, 32'(g), 32'(e));
    end
  endtask

  initial begin
    res_b     = 1'b0;
    bus_gnt   = 1'b1;
    evt_valid = 1'b0;
    evt_data  = 8'h00;
    repeat (3) step;

    // reset values
    check("rst_evt_ready", 32'(evt_ready), 32'd0);
    check("rst_bus_req",   32'(bus_req),   32'd0);
    check("rst_strobe",    32'(pi_write_strobe), 32'd0);
    check("rst_addr",      32'(addr),      32'hE800);
    check("rst_data",      32'(data_out),  32'hFF);
    check("rst_busy",      32'(busy),      32'd1);
    check("rst_err",       32'(err_count), 32'd0);

    // INIT sweep
    res_b = 1'b1;
    wait_ready(200);
    check("sweep_busy", 32'(busy), 32'd0);
    wait_writes(10, 5);
    expect_sweep;
    compare_writes("sweep_write");

    // press r3c5, then release; latency from push to strobe rise
    push_evt(8'h9D);
    wait_writes(1, 20);
    check("latency", strobe_cyc - push_cyc, 32'd4);
    expect_evt(8'h9D);
    compare_writes("press_r3c5");
    push_evt(8'h1D);
    wait_writes(1, 20);
    expect_evt(8'h1D);
    compare_writes("release_r3c5");
    wait_idle(20);

    // fill FIFO with grant withheld, then release grant
    bus_gnt = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      logic [7:0] d;
      d = {1'b1, 4'(i % 10), 3'((i * 3) % 8)};
      push_evt(d);
      expect_evt(d);
    end
    check("full_evt_ready", 32'(evt_ready), 32'd0);
    check("full_bus_req",   32'(bus_req),   32'd1);
    check("full_no_strobe", 32'(wq.size()), 32'd0);
    bus_gnt = 1'b1;
    wait_writes(16, 200);
    compare_writes("fill_order");
    wait_idle(20);

    // release-all
    push_evt(8'h80);
    expect_evt(8'h80);
    push_evt(8'hCF);
    expect_evt(8'hCF);
    wait_writes(2, 40);
    compare_writes("pre_clear");
    wait_idle(20);
    err_base = err_count;
    push_evt(8'hFF);
`ifdef KBD_CLEAR_EN
    wait_writes(10, 200);
    expect_sweep;
    compare_writes("clear_sweep");
    wait_idle(20);
    check("clear_err", 32'(err_count), 32'(err_base));
`else
    wait_idle(40);
    check("ff_dropped_err", 32'(err_count), 32'(err_base) + 32'd1);
    check("ff_no_write", 32'(wq.size()), 32'd0);
`endif

    // bad rows: single drop, then saturation
    err_base = err_count;
    push_evt(8'hD0);
    wait_idle(40);
    check("bad_row_err", 32'(err_count), 32'(err_base) + 32'd1);
    check("bad_row_no_write", 32'(wq.size()), 32'd0);
    for (int unsigned i = 0; i < 299; i++) push_evt(8'h50 + 8'(i % 48));
    wait_idle(100);
    check("err_saturate", 32'(err_count), 32'hFF);
    check("bad_no_writes", 32'(wq.size()), 32'd0);

    // reset during STROBE
    push_evt(8'h88);
    begin
      int unsigned k;
      k = 0;
      while (!pi_write_strobe && k < 20) begin
        step;
        k++;
      end
      check("reach_strobe", 32'(pi_write_strobe), 32'd1);
    end
    res_b = 1'b0;
    #1;
    check("midrst_strobe",  32'(pi_write_strobe), 32'd0);
    check("midrst_bus_req", 32'(bus_req),   32'd0);
    check("midrst_addr",    32'(addr),      32'hE800);
    check("midrst_ready",   32'(evt_ready), 32'd0);
    wq.delete();
    step;
    res_b = 1'b1;
    wait_ready(200);
    wait_writes(10, 5);
    expect_sweep;
    compare_writes("resweep_write");
    check("resweep_err", 32'(err_count), 32'd0);
    push_evt(8'h88);
    wait_writes(1, 20);
    expect_evt(8'h88);
    compare_writes("post_rst_shadow");
    wait_idle(20);

    check("strobe_one_cycle", strobe_long, 32'd0);
    check("addr_data_stable", unstable, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
